mux_tree_pipe: RTL and testbench

MUX_TREE_PIPE -- requirements
Module: mux_tree_pipe

---
 rtl/mux_tree_pipe_pkg.sv | 51 +++++
 rtl/mux_tree_pipe_if.sv | 29 ++
 rtl/mux_tree_pipe_mux4_stage.sv | 66 ++++++
 rtl/mux_tree_pipe.sv | 103 ++++++++++
 tb/tb_mux_tree_pipe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux_tree_pipe_pkg.sv
// Shared definitions for the pipelined 4:1 mux tree.
// Contents: select-slice width, level-count function clog4(), stage
// bookkeeping helpers and the parameter legality checks used at elaboration.
package mux_tree_pipe_pkg;

    // Each tree level consumes this many select bits.
    localparam int unsigned SEL_SLICE_W = 2;
    localparam int unsigned W_MIN       = 1;
    localparam int unsigned W_MAX       = 32;
    localparam int unsigned N_MAX       = 64;

    // Number of 4:1 levels needed to reduce n channels to one.
    function automatic int unsigned clog4(input int unsigned n);
        int unsigned lvl;
        int unsigned span;
        lvl  = 0;
        span = 1;
        for (int i = 0; i < 16; i++) begin
            if (span < n) begin
                span = span * 4;
                lvl  = lvl + 1;
            end
        end
        return lvl;
    endfunction

    // True when n is 4, 16 or 64.
    function automatic bit n_is_pow4(input int unsigned n);
        return (n >= 4) && (n <= N_MAX) && ((32'd1 << (2 * clog4(n))) == n);
    endfunction

    function automatic bit w_in_range(input int unsigned w);
        return (w >= W_MIN) && (w <= W_MAX);
    endfunction

    // Flat index of the first stage of level lvl (level 0 holds n/4 stages).
    function automatic int unsigned stage_base(input int unsigned n, input int unsigned lvl);
        int unsigned base;
        base = 0;
        for (int unsigned i = 0; i < lvl; i++) begin
            base = base + (n >> (2 * (i + 1)));
        end
        return base;
    endfunction

    // Total number of mux4 stages in the tree.
    function automatic int unsigned stage_count(input int unsigned n);
        return stage_base(n, clog4(n));
    endfunction

endpackage

// File: rtl/mux_tree_pipe_if.sv
// Streaming bus of the mux tree.
// Upstream side: I (N*W channel data), S (direct select), SCAN_EN,
// IN_VALID / IN_READY. Downstream side: OUT, OUT_CH, OUT_VALID / OUT_READY.
// master = traffic generator/consumer, slave = the mux tree.
interface mux_tree_pipe_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 16,
    parameter int unsigned SW = 4
) ();
    logic [N*W-1:0] I;
    logic [SW-1:0]  S;
    logic           SCAN_EN;
    logic           IN_VALID;
    logic           IN_READY;
    logic [W-1:0]   OUT;
    logic [SW-1:0]  OUT_CH;
    logic           OUT_VALID;
    logic           OUT_READY;

    modport master (
        output I, S, SCAN_EN, IN_VALID, OUT_READY,
        input  IN_READY, OUT, OUT_CH, OUT_VALID
    );

    modport slave (
        input  I, S, SCAN_EN, IN_VALID, OUT_READY,
        output IN_READY, OUT, OUT_CH, OUT_VALID
    );
endinterface

// File: rtl/mux_tree_pipe_mux4_stage.sv
// mux4_stage: one registered W-bit 4:1 mux of the tree.
// Ports: clk, rst (sync, active-high), en (advance), vld_i/tag_i (slot valid
// and channel tag passed through), sel_i (2-bit leg select), d_i (four legs,
// leg k at [k*W +: W]), q_o/vld_o/tag_o (registered results).
module mux4_stage
    import mux_tree_pipe_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned TW = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   vld_i,
    input  logic [TW-1:0]          tag_i,
    input  logic [SEL_SLICE_W-1:0] sel_i,
    input  logic [4*W-1:0]         d_i,
    output logic [W-1:0]           q_o,
    output logic                   vld_o,
    output logic [TW-1:0]          tag_o
);

    logic [W-1:0]  q_q,   q_d;
    logic          vld_q, vld_d;
    logic [TW-1:0] tag_q, tag_d;

    // Next-state: pick a leg when advancing, otherwise hold.
    always_comb begin
        q_d   = q_q;
        vld_d = vld_q;
        tag_d = tag_q;
        if (en) begin
            vld_d = vld_i;
            tag_d = tag_i;
            case (sel_i)
                2'd0:    q_d = d_i[0 +: W];
                2'd1:    q_d = d_i[W +: W];
                2'd2:    q_d = d_i[2*W +: W];
                2'd3:    q_d = d_i[3*W +: W];
                default: q_d = d_i[0 +: W];
            endcase
        end else begin
            q_d   = q_q;
            vld_d = vld_q;
            tag_d = tag_q;
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= {W{1'b0}};
            vld_q <= 1'b0;
            tag_q <= {TW{1'b0}};
        end else begin
            q_q   <= q_d;
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    assign q_o   = q_q;
    assign vld_o = vld_q;
    assign tag_o = tag_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: N-channel W-bit selector built as a registered tree of
// 4:1 muxes (one register level per 2 select bits), with valid/ready
// handshake and an optional internal scan counter as the select source.
// Ports: CLK, RST (sync, active-high), bus (mux_tree_pipe_if.slave).
module mux_tree_pipe
    import mux_tree_pipe_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 16,
    parameter int unsigned SW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mux_tree_pipe_if.slave bus
);

    localparam int unsigned L = clog4(N);
    localparam int unsigned T = stage_count(N);

    if (!n_is_pow4(N) || (SW != SEL_SLICE_W * L) || !w_in_range(W)) begin : g_bad_params
        $error("mux_tree_pipe: N must be 4/16/64, SW must be log2(N), W must be 1..32");
    end

    logic          en_s;
    logic          xfer_s;
    logic [SW-1:0] sel_eff_s;
    logic [SW-1:0] sc_q, sc_d;

    logic [W-1:0]  leaf_s [N];
    logic [W-1:0]  node_s [T];
    logic          vld_s  [T];
    logic [SW-1:0] tag_s  [T];

    // Handshake, effective select and scan counter next state.
    always_comb begin
        en_s   = !bus.OUT_VALID || bus.OUT_READY;
        xfer_s = bus.IN_VALID && en_s;
        if (bus.SCAN_EN) begin
            sel_eff_s = sc_q;
        end else begin
            sel_eff_s = bus.S;
        end
        if (xfer_s && bus.SCAN_EN) begin
            sc_d = sc_q + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            sc_d = sc_q;
        end
    end

    // Scan counter register; wraps naturally since N = 2**SW.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sc_q <= {SW{1'b0}};
        end else begin
            sc_q <= sc_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_leaf
        assign leaf_s[k] = bus.I[k*W +: W];
    end

    for (genvar j = 0; j < L; j++) begin : g_lvl
        localparam int unsigned M  = N >> (2 * (j + 1));
        localparam int unsigned SB = stage_base(N, j);
        for (genvar m = 0; m < M; m++) begin : g_mux
            logic          vld_in_s;
            logic [SW-1:0] tag_in_s;
            logic [4*W-1:0] d_in_s;
            if (j == 0) begin : g_first
                assign vld_in_s = xfer_s;
                assign tag_in_s = sel_eff_s;
                assign d_in_s   = {leaf_s[4*m+3], leaf_s[4*m+2], leaf_s[4*m+1], leaf_s[4*m]};
            end else begin : g_inner
                localparam int unsigned PB = stage_base(N, j - 1) + 4 * m;
                // All stages of a level hold the same slot, so the four
                // upstream valid/tag copies are identical; OR-ing them just
                // forwards that common value.
                assign vld_in_s = vld_s[PB] | vld_s[PB+1] | vld_s[PB+2] | vld_s[PB+3];
                assign tag_in_s = tag_s[PB] | tag_s[PB+1] | tag_s[PB+2] | tag_s[PB+3];
                assign d_in_s   = {node_s[PB+3], node_s[PB+2], node_s[PB+1], node_s[PB]};
            end
            mux4_stage #(.W(W), .TW(SW)) u_stage (
                .clk   (CLK),
                .rst   (RST),
                .en    (en_s),
                .vld_i (vld_in_s),
                .tag_i (tag_in_s),
                .sel_i (tag_in_s[2*j +: 2]),
                .d_i   (d_in_s),
                .q_o   (node_s[SB+m]),
                .vld_o (vld_s[SB+m]),
                .tag_o (tag_s[SB+m])
            );
        end
    end

    assign bus.IN_READY  = en_s;
    assign bus.OUT       = node_s[T-1];
    assign bus.OUT_CH    = tag_s[T-1];
    assign bus.OUT_VALID = vld_s[T-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe (N=16, W=8): directed scenarios
// followed by random traffic, checked by a scoreboard fed at input transfer
// time and drained by an independent output monitor.
module tb_mux_tree_pipe;
    localparam int W  = 8;
    localparam int N  = 16;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_tree_pipe_if #(.W(W), .N(N), .SW(SW)) bus ();
    mux_tree_pipe #(.W(W), .N(N), .SW(SW)) dut (.CLK(clk), .RST(rst), .bus(bus));

    typedef struct packed {
        logic [W-1:0]  data;
        logic [SW-1:0] ch;
    } exp_t;

    exp_t          sb [$];
    logic [SW-1:0] ch_log [$];
    int            checks   = 0;
    int            failures = 0;
    int            out_cnt  = 0;
    int unsigned   sc_m     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock: record an accepted sample in the reference model, then move
    // to just after the next rising edge.
    task automatic step();
        logic [SW-1:0]  ch;
        logic [N*W-1:0] sh;
        exp_t           e;
        @(negedge clk);
        if (!rst && bus.IN_VALID && bus.IN_READY) begin
            ch = bus.SCAN_EN ? sc_m[SW-1:0] : bus.S;
            sh = bus.I >> (int'(ch) * W);
            e.data = sh[W-1:0];
            e.ch   = ch;
            sb.push_back(e);
            if (bus.SCAN_EN) sc_m = (sc_m + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        bus.I = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain(input string name);
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() != 0) step();
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        sb.delete();
        sc_m = 0;
        step();
        rst = 1'b0;
    endtask

    // Output monitor: handshake rule, stall hold and scoreboard compare.
    logic          hold_chk = 1'b0;
    logic [W-1:0]  held_out;
    logic [SW-1:0] held_ch;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("in_ready_rule", 32'(bus.IN_READY), 32'(!bus.OUT_VALID || bus.OUT_READY));
            if (hold_chk) begin
                check("stall_hold_valid", 32'(bus.OUT_VALID), 32'd1);
                check("stall_hold_out", 32'(bus.OUT), 32'(held_out));
                check("stall_hold_ch", 32'(bus.OUT_CH), 32'(held_ch));
            end
            if (bus.OUT_VALID && bus.OUT_READY) begin
                out_cnt++;
                ch_log.push_back(bus.OUT_CH);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_output actual_ch=%0d required=none", bus.OUT_CH);
                end else begin
                    e = sb.pop_front();
                    check("sb_ch", 32'(bus.OUT_CH), 32'(e.ch));
                    check("sb_data", 32'(bus.OUT), 32'(e.data));
                end
            end
            hold_chk = bus.OUT_VALID && !bus.OUT_READY;
            held_out = bus.OUT;
            held_ch  = bus.OUT_CH;
        end else begin
            hold_chk = 1'b0;
        end
    end

    initial begin
        int   c0;
        logic v [5];
        rst           = 1'b1;
        bus.I         = '0;
        bus.S         = '0;
        bus.SCAN_EN   = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        #1;
        step();
        step();
        check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst_out", 32'(bus.OUT), 32'd0);
        check("rst_out_ch", 32'(bus.OUT_CH), 32'd0);
        check("rst_sc", 32'(dut.sc_q), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.IN_READY), 32'd1);

        // Direct select, exact two-cycle latency.
        for (int k = 0; k < N; k++) bus.I[k*W +: W] = 8'h10 + 8'(k);
        bus.S = 4'd5; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
        step();
        bus.IN_VALID = 1'b0;
        check("direct_not_early", 32'(bus.OUT_VALID), 32'd0);
        step();
        check("direct_valid", 32'(bus.OUT_VALID), 32'd1);
        check("direct_out", 32'(bus.OUT), 32'h15);
        check("direct_ch", 32'(bus.OUT_CH), 32'd5);
        drain("direct_drain");

        // Scan: 18 back-to-back transfers, one output per cycle.
        bus.SCAN_EN = 1'b1; bus.IN_VALID = 1'b1;
        c0 = out_cnt;
        for (int i = 0; i < 18; i++) begin rand_data(); step(); end
        bus.IN_VALID = 1'b0;
        step(); step();
        check("scan_throughput", 32'(out_cnt - c0), 32'd18);
        for (int i = 0; i < 18; i++)
            check("scan_ch_seq", 32'(ch_log[ch_log.size() - 18 + i]), 32'(i % N));
        drain("scan_drain");

        // Backpressure mid-stream.
        bus.SCAN_EN = 1'b0; bus.IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin rand_data(); bus.S = 4'($urandom); step(); end
        for (int i = 0; i < 3; i++) begin
            bus.OUT_READY = 1'b0; rand_data(); bus.S = 4'($urandom);
            #1;
            check("bp_in_ready_low", 32'(bus.IN_READY), 32'd0);
            step();
        end
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 2; i++) begin rand_data(); step(); end
        drain("bp_drain");

        // Bubble pattern 1,0,1 shows up on OUT_VALID two cycles later.
        bus.S = 4'd3;
        for (int i = 0; i < 5; i++) begin
            bus.IN_VALID = (i == 0 || i == 2);
            rand_data();
            step();
            v[i] = bus.OUT_VALID;
        end
        check("bubble_v0", 32'(v[0]), 32'd0);
        check("bubble_v1", 32'(v[1]), 32'd1);
        check("bubble_v2", 32'(v[2]), 32'd0);
        check("bubble_v3", 32'(v[3]), 32'd1);
        check("bubble_v4", 32'(v[4]), 32'd0);
        drain("bubble_drain");

        // Reset with two samples in flight, while stalled.
        bus.SCAN_EN = 1'b1; bus.IN_VALID = 1'b1;
        rand_data(); step(); rand_data(); step();
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
        pulse_reset();
        check("mid_rst_valid", 32'(bus.OUT_VALID), 32'd0);
        check("mid_rst_out", 32'(bus.OUT), 32'd0);
        check("mid_rst_ch", 32'(bus.OUT_CH), 32'd0);
        check("mid_rst_sc", 32'(dut.sc_q), 32'd0);
        bus.OUT_READY = 1'b1; bus.IN_VALID = 1'b1; rand_data();
        step();
        bus.IN_VALID = 1'b0;
        step();
        check("post_rst_valid", 32'(bus.OUT_VALID), 32'd1);
        check("post_rst_ch", 32'(bus.OUT_CH), 32'd0);
        drain("post_rst_drain");

        // Mode switch: scan x3, direct S=9, scan again.
        pulse_reset();
        bus.IN_VALID = 1'b1; bus.SCAN_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_data(); step(); end
        bus.SCAN_EN = 1'b0; bus.S = 4'd9; rand_data(); step();
        bus.SCAN_EN = 1'b1; bus.S = 4'd0; rand_data(); step();
        drain("mode_drain");
        check("mode_ch0", 32'(ch_log[ch_log.size() - 5]), 32'd0);
        check("mode_ch1", 32'(ch_log[ch_log.size() - 4]), 32'd1);
        check("mode_ch2", 32'(ch_log[ch_log.size() - 3]), 32'd2);
        check("mode_ch3", 32'(ch_log[ch_log.size() - 2]), 32'd9);
        check("mode_ch4", 32'(ch_log[ch_log.size() - 1]), 32'd3);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rand_data();
            bus.S         = 4'($urandom);
            bus.SCAN_EN   = ($urandom_range(0, 3) != 0);
            bus.IN_VALID  = ($urandom_range(0, 4) != 0);
            bus.OUT_READY = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
